// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its decade digits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_CLEAR = 2'd2,
    CMD_LAP   = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX = 4'd9;

endpackage

// File: rtl/decade_digit.sv
// Single BCD decade counter (0-9, wraps to 0); clear has priority over increment.
module decade_digit
  import stopwatch_pkg::*;
(
  input  logic CLK,
  input  logic RESET_N,
  input  logic CLR,
  input  logic INC,
  output bcd_t VALUE,
  output logic AT_MAX
);

  bcd_t value_q;
  bcd_t value_d;

  always_comb begin
    value_d = value_q;
    if (CLR) begin
      value_d = '0;
    end else if (INC) begin
      value_d = (value_q == DIGIT_MAX) ? bcd_t'(0) : bcd_t'(value_q + 4'd1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign VALUE  = value_q;
  assign AT_MAX = (value_q == DIGIT_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/stop/clear sequencer for a chain of decade digits with prescaler, lap
// capture and sticky overflow.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  CMD_VALID,
  input  logic [1:0]            CMD,
  output logic                  CMD_READY,
  output logic [4*DIGITS-1:0]   COUNT,
  output logic [4*DIGITS-1:0]   LAP,
  output logic                  RUNNING,
  output logic                  OVERFLOW
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  state_e              state_q, state_d;
  logic [PS_W-1:0]     ps_q, ps_d;
  logic [4*DIGITS-1:0] lap_q, lap_d;
  logic                running_q, running_d;
  logic                overflow_q, overflow_d;

  logic                accept;
  cmd_e                cmd;
  logic                tick;
  logic                clear_cmd;
  logic [DIGITS:0]     carry;
  logic [DIGITS-1:0]   at_max;
  logic [4*DIGITS-1:0] count_w;

  assign cmd       = cmd_e'(CMD);
  assign CMD_READY = (state_q != ST_CLEAR);
  assign accept    = CMD_VALID && CMD_READY;
  assign tick      = (state_q == ST_RUN) && (ps_q == PS_LAST);
  assign clear_cmd = accept && (cmd == CMD_CLEAR);

  // Carry ripples through every digit sitting at 9 within the same cycle.
  assign carry[0] = tick;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign carry[i+1] = carry[i] & at_max[i];

    decade_digit u_digit (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .CLR     (clear_cmd),
      .INC     (carry[i]),
      .VALUE   (count_w[4*i +: 4]),
      .AT_MAX  (at_max[i])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && cmd == CMD_START) state_d = ST_RUN;
        if (accept && cmd == CMD_CLEAR) state_d = ST_CLEAR;
      end
      ST_RUN: begin
        if (accept && cmd == CMD_STOP)  state_d = ST_IDLE;
        if (accept && cmd == CMD_CLEAR) state_d = ST_CLEAR;
      end
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Clear overrides any tick or overflow arriving in the same cycle.
  always_comb begin
    ps_d       = ps_q;
    lap_d      = lap_q;
    overflow_d = overflow_q | carry[DIGITS];
    running_d  = (state_d == ST_RUN);
    if (state_q == ST_RUN) begin
      ps_d = tick ? '0 : ps_q + 1'b1;
    end
    if (accept && cmd == CMD_LAP) begin
      lap_d = count_w;
    end
    if (clear_cmd) begin
      ps_d       = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      ps_q       <= '0;
      lap_q      <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ps_q       <= ps_d;
      lap_q      <= lap_d;
      running_q  <= running_d;
      overflow_q <= overflow_d;
    end
  end

  assign COUNT    = count_w;
  assign LAP      = lap_q;
  assign RUNNING  = running_q;
  assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl against an integer-valued stopwatch model.
module tb_stopwatch_ctrl;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 4;
  localparam int MOD      = 100;

  logic                CLK;
  logic                RESET_N;
  logic                CMD_VALID;
  logic [1:0]          CMD;
  logic                CMD_READY;
  logic [4*DIGITS-1:0] COUNT;
  logic [4*DIGITS-1:0] LAP;
  logic                RUNNING;
  logic                OVERFLOW;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: count/lap held as plain decimal integers.
  bit m_running, m_clearing, m_ovf;
  int m_ps, m_count, m_lap;

  stopwatch_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .CMD_VALID (CMD_VALID),
    .CMD       (CMD),
    .CMD_READY (CMD_READY),
    .COUNT     (COUNT),
    .LAP       (LAP),
    .RUNNING   (RUNNING),
    .OVERFLOW  (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int p;
    r = '0;
    p = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(p % 10);
      p = p / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("count",     32'(COUNT),     to_bcd(m_count));
    checkOutput("lap",       32'(LAP),       to_bcd(m_lap));
    checkOutput("running",   32'(RUNNING),   32'(m_running));
    checkOutput("overflow",  32'(OVERFLOW),  32'(m_ovf));
    checkOutput("cmd_ready", 32'(CMD_READY), 32'(!m_clearing));
  endtask

  task automatic resetModel();
    m_running  = 0;
    m_clearing = 0;
    m_ovf      = 0;
    m_ps       = 0;
    m_count    = 0;
    m_lap      = 0;
  endtask

  // Drive one cycle of input, advance the model by the stopwatch rules, then compare.
  task automatic applyStimulus(input bit valid, input logic [1:0] cmd);
    bit acc, tick, n_running, n_clearing, n_ovf;
    int n_ps, n_count, n_lap;
    CMD_VALID = valid;
    CMD       = cmd;
    checkOutput("cmd_ready_pre", 32'(CMD_READY), 32'(!m_clearing));
    acc        = valid && !m_clearing;
    tick       = m_running && (m_ps == PRESCALE - 1);
    n_running  = m_running;
    n_clearing = 0;
    n_ovf      = m_ovf;
    n_ps       = m_ps;
    n_count    = m_count;
    n_lap      = m_lap;
    if (tick) begin
      n_ps = 0;
      if (m_count == MOD - 1) n_ovf = 1;
      n_count = (m_count + 1) % MOD;
    end else if (m_running) begin
      n_ps = m_ps + 1;
    end
    if (acc) begin
      case (cmd)
        2'd0: n_running = 1;
        2'd1: n_running = 0;
        2'd2: begin
          n_clearing = 1;
          n_running  = 0;
          n_count    = 0;
          n_ps       = 0;
          n_ovf      = 0;
        end
        default: n_lap = m_count;
      endcase
    end
    @(posedge CLK);
    #1;
    m_running  = n_running;
    m_clearing = n_clearing;
    m_ovf      = n_ovf;
    m_ps       = n_ps;
    m_count    = n_count;
    m_lap      = n_lap;
    checkAll();
  endtask

  // Asynchronous reset between edges: outputs must clear before any clock edge.
  task automatic resetCheck();
    RESET_N = 1'b0;
    #2;
    resetModel();
    checkAll();
    RESET_N = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0);
  endtask

  initial begin
    int r;
    RESET_N   = 1'b1;
    CMD_VALID = 1'b0;
    CMD       = 2'd0;
    resetModel();
    @(posedge CLK);
    #1;
    resetCheck();

    // First tick lands PRESCALE+1 cycles after START is accepted.
    applyStimulus(1'b1, 2'd0);
    checkOutput("running_after_start", 32'(RUNNING), 32'd1);
    idleCycles(4);
    checkOutput("first_count", 32'(COUNT), 32'h01);
    idleCycles(4);
    checkOutput("second_count", 32'(COUNT), 32'h02);
    idleCycles(160);
    checkOutput("ripple_to_42", 32'(COUNT), 32'h42);

    // Stop, hold, resume; then lap and reset mid-count.
    applyStimulus(1'b1, 2'd1);
    idleCycles(20);
    applyStimulus(1'b1, 2'd0);
    idleCycles(6);
    applyStimulus(1'b1, 2'd3);
    idleCycles(9);
    resetCheck();
    checkOutput("reset_count", 32'(COUNT), 32'h00);

    // Overflow from 99 to 00, sticky until CLEAR; LAP held through CLEAR.
    applyStimulus(1'b1, 2'd0);
    idleCycles(420);
    checkOutput("overflow_set", 32'(OVERFLOW), 32'd1);
    applyStimulus(1'b1, 2'd3);
    applyStimulus(1'b1, 2'd2);
    checkOutput("clear_ready_low", 32'(CMD_READY), 32'd0);
    applyStimulus(1'b1, 2'd0);
    checkOutput("start_blocked_in_clear", 32'(RUNNING), 32'd0);
    applyStimulus(1'b1, 2'd0);
    checkOutput("overflow_cleared", 32'(OVERFLOW), 32'd0);

    // Randomised command traffic with occasional asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 2) begin
        resetCheck();
      end else if (r < 60) begin
        applyStimulus(1'b1, 2'd0);
      end else if (r < 90) begin
        applyStimulus(1'b1, 2'd1);
      end else if (r < 100) begin
        applyStimulus(1'b1, 2'd2);
      end else if (r < 160) begin
        applyStimulus(1'b1, 2'd3);
      end else begin
        applyStimulus(1'b0, 2'($urandom_range(0, 3)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/stop/clear controller that sequences a chain of decade (0–9, wrap-to-0) digit counters driven by a prescaled tick. Accepts single-command valid/ready requests, owns the prescaler and the carry ripple between digits, and provides a lap capture register. Sits between the host command interface and the BCD display/readout path.

## Interface
- DIGITS, 4, number of cascaded decade digits (1–8)
- PRESCALE, 10, CLK cycles per count increment (≥2)
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  command request
- CMD  in  2  command: 0 START, 1 STOP, 2 CLEAR, 3 LAP
- CMD_READY  out  1  controller can accept a command this cycle
- COUNT  out  4*DIGITS  BCD count, digit 0 in bits [3:0]
- LAP  out  4*DIGITS  BCD snapshot of COUNT at last accepted LAP
- RUNNING  out  1  high in RUN state
- OVERFLOW  out  1  sticky: chain wrapped from all-9s to all-0s

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, RUN, CLEAR. Reset → IDLE.
- Accept = CMD_VALID && CMD_READY. CMD_READY = 1 in IDLE and RUN, 0 in CLEAR.
- IDLE: START → RUN; CLEAR → CLEAR; STOP → no-op; LAP → capture.
- RUN: STOP → IDLE; CLEAR → CLEAR; START → no-op; LAP → capture, stay RUN.
- CLEAR: for exactly one cycle; COUNT, prescaler and OVERFLOW are zeroed on entry; next state IDLE unconditionally. LAP is not cleared.
- Prescaler PS (ceil(log2 PRESCALE) bits): increments each cycle in RUN; frozen in IDLE (resumes from held value on START); PS == PRESCALE-1 in RUN → tick, PS ← 0.
- Tick: digit 0 increments; digit i increments iff tick and digits 0..i-1 all == 9; digit at 9 that increments → 0. Full ripple in one cycle.
- Tick with all digits 9 → COUNT all 0, OVERFLOW ← 1 (sticky until CLEAR or reset); counting continues.
- LAP captures COUNT as registered in the accept cycle (pre-increment if tick in same cycle).
- Digits only ever hold 0–9.

## Timing
- Reset values: COUNT 0, LAP 0, RUNNING 0, OVERFLOW 0, PS 0, CMD_READY 1 (IDLE).
- All outputs registered except CMD_READY (decoded from state).
- START accepted in cycle t (from PS = 0): RUNNING = 1 at t+1; PS = 0..PRESCALE-1 over cycles t+1..t+PRESCALE; tick in cycle t+PRESCALE; COUNT = 1 visible at t+PRESCALE+1.
- STOP accepted in a tick cycle: that tick still applies; RUNNING = 0 next cycle.
- CLEAR accepted in a tick cycle: clear wins, COUNT = 0 next cycle.
- LAP visible at accept cycle +1.
- Reset mid-operation: all state returns to reset values immediately; no partial commands retained.

## Structure
- Package stopwatch_pkg: cmd_e (START/STOP/CLEAR/LAP), state_e (IDLE/RUN/CLEAR), BCD digit typedef (4-bit), DIGIT_MAX = 9.
- Sub-module decade_digit: ports CLK, RESET_N, CLR, INC, value out, at_max out (value == 9); instantiated DIGITS times via generate; carry chain (AND of at_max) built in stopwatch_ctrl.

## Test plan
(DIGITS=2, PRESCALE=4 unless stated)
- Reset: assert RESET_N=0 mid-count at COUNT=0x37 → COUNT 0x00, LAP 0x00, RUNNING 0, OVERFLOW 0 without a clock edge; CMD_READY 1 after.
- START at t: RUNNING 1 at t+1; COUNT 0x01 at t+5, 0x02 at t+9; after 40 ticks COUNT 0x40 (ripple 0x09→0x10 correct).
- STOP at COUNT=0x05 with PS=2, wait 20 cycles → COUNT holds 0x05; START → next increment to 0x06 exactly 2 cycles after RUNNING returns high.
- Overflow: run to 0x99, next tick → COUNT 0x00, OVERFLOW 1; OVERFLOW stays 1 through later ticks; CLEAR → OVERFLOW 0, COUNT 0x00, CMD_READY 0 for one cycle, state IDLE.
- Simultaneous: CLEAR accepted in tick cycle at 0x12 → COUNT 0x00 (not 0x13); STOP in tick cycle at 0x12 → COUNT 0x13, RUNNING 0.
- LAP in tick cycle at 0x29 → LAP 0x29, COUNT 0x30; LAP survives CLEAR; CMD_VALID held during CLEAR → accepted only in following IDLE cycle.
